sobel_row_serializer: RTL
=========================

# sobel_row_serializer

Output-side companion to `sobel_filter_scalable`. It accepts whole filtered rows (WIDTH parallel 8-bit pixels per cycle) and buffers up to two of them. It then emits the rows as a serial pixel stream with a valid/ready handshake, carrying row-end and frame-end markers. The block sits between the filter's `arr_out` and the downstream pixel sink (display/DMA), converting the filter's row-parallel output into one pixel per cycle.

## Interface

Parameters:
- `WIDTH`, 3: pixels per input row. Equals filter SIZE-2. Must be ≥ 1.
- `ROWS`, 3: rows per frame. Used only for `pix_frame_end`. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock. All logic acts on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `row_in`, input, [7:0] × WIDTH (unpacked, index 0 = leftmost): filtered row from the filter.
- `row_valid`, input, 1: `row_in` holds a row.
- `row_ready`, output, 1: the block can accept a row this cycle.
- `pix_out`, output, 8: current output pixel.
- `pix_valid`, output, 1: `pix_out` is valid.
- `pix_ready`, input, 1: the sink accepts the pixel.
- `pix_last`, output, 1: `pix_out` is the last pixel of its row (column WIDTH-1).
- `pix_frame_end`, output, 1: `pix_out` is the last pixel of the last row of the frame.

## Operation

- **Row storage.** Two row slots, `wr_ptr` (1 bit), `rd_ptr` (1 bit), `count` (0..2), `col` (0..WIDTH-1), `row_cnt` (0..ROWS-1).
- **States.** State is implied by `count`: EMPTY (0), ONE (1), FULL (2).
- **Row accept.** `row_ready = (count != 2)`, which is combinational from registered state.
  - Accept occurs when `row_valid && row_ready`.
  - On accept, `row_in` is written to slot `wr_ptr` and `wr_ptr` toggles.
  - `row_valid` without `row_ready` has no effect. The upstream must hold the row; the filter side stalls.
- **Pixel output.**
  - `pix_valid = (count != 0)`.
  - `pix_out = slot[rd_ptr][col]` while valid, else 8'd0.
  - `pix_last = pix_valid && col == WIDTH-1`.
  - `pix_frame_end = pix_last && row_cnt == ROWS-1`.
- **Pixel handshake.**
  - On `pix_valid && pix_ready`: if `col < WIDTH-1`, `col` increments.
  - Otherwise the row pops: `col` goes to 0, `rd_ptr` toggles, `count` decrements, and `row_cnt` increments, wrapping to 0 after ROWS-1.
  - With `pix_ready` low, all output signals stay stable.
- **State transitions.**
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without pop.
  - ONE→EMPTY on pop without accept.
  - ONE→ONE on accept and pop in the same cycle: both take effect, and the written slot ≠ the read slot.
  - FULL→ONE on pop. Accept is impossible in FULL because `row_ready` = 0. There is no same-cycle bypass from FULL.
- **WIDTH = 1.** Every pixel handshake is a pop, and `pix_last` is always 1 when valid.
- **Arithmetic.** None on pixel data; pixels are passed through unmodified.

## Timing

- **Reset.** Assertion is asynchronous and takes effect immediately. Reset state:
  - `count` = 0, `wr_ptr` = 0, `rd_ptr` = 0, `col` = 0, `row_cnt` = 0, and slot contents = 0.
  - Therefore `row_ready` = 1, `pix_valid` = 0, `pix_out` = 0, `pix_last` = 0, `pix_frame_end` = 0.
- **Reset mid-row.** Buffered rows and any partial row are discarded. The first row after release is frame row 0.
- **Latency.** A row accepted at edge N presents pixel 0 in the cycle after edge N, when `pix_valid` rises.
- **Throughput.** One pixel per cycle with `pix_ready` held high. A new row is sustainable every WIDTH cycles without a gap in `pix_valid`.
- **Filter-rate mismatch.** With the filter delivering a row every cycle and WIDTH > 1, `row_ready` drops after two rows. This is required behaviour.

## Structure

- **Shared package `sobel_pkg`:**
  - `PIX_W` = 8
  - `typedef logic [PIX_W-1:0] pixel_t`
  - Used in common with `sobel_filter_scalable` and its bench.
- **Sub-module `sobel_row_fifo`:**
  - Holds the 2-entry, WIDTH-pixel row store with pointers and count.
  - Provides push/pop and full/empty signals.
  - The top level holds `col`, `row_cnt`, and output decode.

## Test plan

- **Single row.** Reset, then one row {60,82,71} with `pix_ready` = 1.
  - Required: `pix_out` 60, 82, 71 on three consecutive cycles.
  - `pix_last` only on 71; `pix_valid` low afterward.
  - `row_ready` stays 1 throughout.
- **Back-to-back rows, backpressure.** `row_valid` = 1 for rows {121,174,216}, {88,127,165}, {1,2,3}, with `pix_ready` = 0.
  - Required: `row_ready` = 0 after the second accept.
  - The third row is held until the first pop.
  - The stream then reads 121,174,216,88,127,165,1,2,3.
- **Simultaneous accept and pop.** In ONE with `col` = WIDTH-1, `pix_ready` = 1 and `row_valid` = 1 in the same cycle.
  - Required: `count` stays 1 and the next pixel is element 0 of the new row with no bubble.
- **Frame end.** ROWS = 3, four rows streamed.
  - Required: `pix_frame_end` only on the last pixel of row 3.
  - On row 4 the row count has wrapped, so `pix_frame_end` does not fire on row 4's last pixel.
- **Reset mid-row.** Assert `rst_n` low after the second pixel of a row.
  - Required: all outputs take their reset values immediately and stay there while `rst_n` is low.
  - After release, a new row {9,8,7} emits 9 first.
- **Stall stability.** `pix_ready` toggles 1,0,0,1 during a row.
  - Required: `pix_out`, `pix_last` and `pix_valid` hold constant during the stall cycles.
  - No pixel is lost or duplicated.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the sobel filter family: pixel width, pixel type and
// the row-buffer occupancy encoding used by the output serializer.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Occupancy of the two-slot row store; the encoding is the row count itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Index width for a 0..n-1 counter, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_row_serializer_if.sv
// Row-parallel input and pixel-serial output handshakes of the row serializer.
// The block under design takes the slave side; the filter/sink pair is the master.
interface sobel_row_serializer_if
  import sobel_pkg::*;
#(
  parameter int WIDTH = 3
);

  pixel_t row_in [WIDTH];
  logic   row_valid;
  logic   row_ready;
  pixel_t pix_out;
  logic   pix_valid;
  logic   pix_ready;
  logic   pix_last;
  logic   pix_frame_end;

  modport master (
    output row_in, row_valid, pix_ready,
    input  row_ready, pix_out, pix_valid, pix_last, pix_frame_end
  );

  modport slave (
    input  row_in, row_valid, pix_ready,
    output row_ready, pix_out, pix_valid, pix_last, pix_frame_end
  );

endinterface

// File: rtl/sobel_row_fifo.sv
// Two-entry row store: each entry holds one full WIDTH-pixel row.
// Occupancy is kept as an explicit state; pointers pick the write and read slots.
module sobel_row_fifo
  import sobel_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  pixel_t push_row [WIDTH],
  input  logic   pop,
  output pixel_t rd_row [WIDTH],
  output logic   full,
  output logic   empty
);

  fifo_state_t state, state_next;
  logic        wr_ptr, rd_ptr;
  logic        do_push, do_pop;
  pixel_t      slot [2][WIDTH];

  assign full    = (state == FULL);
  assign empty   = (state == EMPTY);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: state and storage use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Push and pop in the same cycle from ONE keeps ONE: the slots differ.
  always_comb begin
    // NOTE: default first, so no branch leaves state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      EMPTY:   if (do_push) state_next = ONE;
      ONE: begin
        if (do_push && !do_pop)      state_next = FULL;
        else if (do_pop && !do_push) state_next = EMPTY;
      end
      FULL:    if (do_pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: slot contents must read as zero after reset, so the store is flops, not a RAM.
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < WIDTH; c++)
          slot[s][c] <= '0;
    end else begin
      if (do_push) begin
        for (int c = 0; c < WIDTH; c++)
          slot[wr_ptr][c] <= push_row[c];
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_comb begin
    for (int c = 0; c < WIDTH; c++)
      rd_row[c] = slot[rd_ptr][c];
  end

endmodule

// File: rtl/sobel_row_serializer.sv
// Turns whole filtered rows into a one-pixel-per-cycle valid/ready stream
// with row-end and frame-end markers; up to two rows are buffered.
module sobel_row_serializer
  import sobel_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int ROWS  = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  sobel_row_serializer_if.slave  bus
);

  localparam int COL_W = idx_w(WIDTH);
  localparam int ROW_W = idx_w(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row_cnt;
  logic             push, pop, full, empty;
  logic             beat, at_col_last;
  pixel_t           rd_row [WIDTH];

  assign bus.row_ready = !full;
  assign bus.pix_valid = !empty;
  assign push          = bus.row_valid && !full;
  assign beat          = !empty && bus.pix_ready;
  assign at_col_last   = (col == COL_LAST);
  assign pop           = beat && at_col_last;

  sobel_row_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_row (bus.row_in),
    .pop      (pop),
    .rd_row   (rd_row),
    .full     (full),
    .empty    (empty)
  );

  // Column walks the current row; the last column's handshake pops the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row_cnt <= '0;
    end else if (beat) begin
      if (at_col_last) begin
        col     <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_comb begin
    bus.pix_out       = '0;
    bus.pix_last      = 1'b0;
    bus.pix_frame_end = 1'b0;
    if (!empty) begin
      bus.pix_out       = rd_row[col];
      bus.pix_last      = at_col_last;
      bus.pix_frame_end = at_col_last && (row_cnt == ROW_LAST);
    end
  end

endmodule
